// File: rtl/foxtrot_pkg.sv
// Shared definitions for the foxtrot out-of-order core slice.
// Holds the datapath widths used by the issue queues and the layout of one
// issue-queue entry, plus a helper that applies a CDB broadcast to an entry.
package foxtrot_pkg;

    localparam int PRN_W   = 7;
    localparam int ID_W    = 6;
    localparam int DATA_W  = 64;
    localparam int NUM_OPS = 3;
    localparam int NUM_OUT = 3;
    localparam int INST_W  = 32;

    // One buffered instruction. Index 0 of each packed array sits in the
    // low-order bits, matching the flat port layout (op[0] = bits DATA_W-1:0).
    typedef struct packed {
        logic                            valid;
        logic [INST_W-1:0]               inst;
        logic [ID_W-1:0]                 id;
        logic [NUM_OPS-1:0][PRN_W-1:0]   op_prn;
        logic [NUM_OPS-1:0]              op_rdy;
        logic [NUM_OPS-1:0][DATA_W-1:0]  op_data;
        logic [NUM_OUT-1:0][PRN_W-1:0]   out_prn;
    } iq_entry_t;

    // Capture a broadcast result into every still-waiting operand slot of a
    // valid entry whose source PRN matches. Already-ready operands keep
    // their value even if the PRN is broadcast again.
    function automatic iq_entry_t iq_wakeup(
        input iq_entry_t          e,
        input logic               cdb_valid,
        input logic [PRN_W-1:0]   cdb_prn,
        input logic [DATA_W-1:0]  cdb_data
    );
        iq_entry_t r;
        r = e;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (e.valid && cdb_valid && !e.op_rdy[k] && (e.op_prn[k] == cdb_prn)) begin
                r.op_rdy[k]  = 1'b1;
                r.op_data[k] = cdb_data;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fu_issue_queue_select.sv
// iq_select: oldest-ready priority encoder for the issue queue.
// Entry 0 is the oldest, so the lowest set bit of the ready vector wins.
//
// Ports:
//   ready  in  DEPTH   per-entry "valid and all operands ready"
//   found  out 1       at least one entry is ready
//   idx    out IDX_W   index of the lowest ready entry (0 when none)
module iq_select #(
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] ready,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan from the youngest slot down so the last match written is the
    // oldest ready entry.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/fu_issue_queue.sv
// fu_issue_queue: collapsing issue queue in front of a single functional unit.
// Buffers dispatched instructions, wakes their operands from the CDB and
// issues the oldest fully-ready one into the FU when the FU is ready.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   disp_valid/disp_ready         dispatch handshake (ready = count < DEPTH)
//   disp_inst, disp_inst_id       instruction word and id
//   disp_op_prn/rdy/data          source PRNs, availability, values
//   disp_out_prn                  destination PRNs
//   cdb_valid/prn/data            result broadcast used for wakeup
//   fu_ready                      FU can take an instruction this cycle
//   inst_valid, inst, inst_id,
//   op, out_prn                   registered issue outputs into the FU
module fu_issue_queue
    import foxtrot_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [INST_W-1:0]          disp_inst,
    input  logic [ID_W-1:0]            disp_inst_id,
    input  logic [NUM_OPS*PRN_W-1:0]   disp_op_prn,
    input  logic [NUM_OPS-1:0]         disp_op_rdy,
    input  logic [NUM_OPS*DATA_W-1:0]  disp_op_data,
    input  logic [NUM_OUT*PRN_W-1:0]   disp_out_prn,
    input  logic                       cdb_valid,
    input  logic [PRN_W-1:0]           cdb_prn,
    input  logic [DATA_W-1:0]          cdb_data,
    input  logic                       fu_ready,
    output logic                       inst_valid,
    output logic [INST_W-1:0]          inst,
    output logic [ID_W-1:0]            inst_id,
    output logic [NUM_OPS*DATA_W-1:0]  op,
    output logic [NUM_OUT*PRN_W-1:0]   out_prn
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    iq_entry_t        entries     [DEPTH];
    iq_entry_t        entries_nxt [DEPTH];
    iq_entry_t        woken       [DEPTH + 1];
    iq_entry_t        disp_entry;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] disp_slot;
    logic [DEPTH-1:0] ready_vec;
    logic             found;
    logic [IDX_W-1:0] sel_idx;
    logic             do_issue;
    logic             do_disp;

    // Space is judged from the registered count only, so an issue in the
    // same cycle never frees a slot early.
    assign disp_ready = (count < CNT_W'(DEPTH));

    // Eligibility comes from registered state, which is what gives the
    // one-edge delay between a CDB wakeup and the entry issuing.
    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = entries[i].valid && (&entries[i].op_rdy);
        end
    end

    iq_select #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_select (
        .ready (ready_vec),
        .found (found),
        .idx   (sel_idx)
    );

    // Next-state of the storage: wake every entry, collapse over the issued
    // slot, then drop the new instruction into the first free slot. The
    // extra all-zero woken[DEPTH] is what shifts into the top slot on a
    // collapse. The dispatching instruction is woken too so a broadcast in
    // its dispatch cycle is not lost.
    always_comb begin
        do_issue  = fu_ready && found;
        do_disp   = disp_valid && disp_ready;
        disp_slot = count - CNT_W'(do_issue);
        count_nxt = count + CNT_W'(do_disp) - CNT_W'(do_issue);

        for (int i = 0; i < DEPTH; i++) begin
            woken[i] = iq_wakeup(entries[i], cdb_valid, cdb_prn, cdb_data);
        end
        woken[DEPTH] = '0;

        disp_entry         = '0;
        disp_entry.valid   = 1'b1;
        disp_entry.inst    = disp_inst;
        disp_entry.id      = disp_inst_id;
        disp_entry.op_prn  = disp_op_prn;
        disp_entry.op_rdy  = disp_op_rdy;
        disp_entry.op_data = disp_op_data;
        disp_entry.out_prn = disp_out_prn;
        disp_entry         = iq_wakeup(disp_entry, cdb_valid, cdb_prn, cdb_data);

        for (int i = 0; i < DEPTH; i++) begin
            if (do_issue && (IDX_W'(i) >= sel_idx)) begin
                entries_nxt[i] = woken[i + 1];
            end else begin
                entries_nxt[i] = woken[i];
            end
            if (do_disp && (CNT_W'(i) == disp_slot)) begin
                entries_nxt[i] = disp_entry;
            end
        end
    end

    // Storage, occupancy and the issue register. The issue outputs only
    // load when an instruction actually leaves, otherwise they hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            count      <= '0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_id    <= '0;
            op         <= '0;
            out_prn    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= entries_nxt[i];
            end
            count      <= count_nxt;
            inst_valid <= do_issue;
            if (do_issue) begin
                inst    <= entries[sel_idx].inst;
                inst_id <= entries[sel_idx].id;
                op      <= entries[sel_idx].op_data;
                out_prn <= entries[sel_idx].out_prn;
            end
        end
    end

endmodule
